spi_master: RTL and testbench
=============================

// Module: spi_master
// PURPOSE
//  Full-duplex SPI master (mode 0, MSB first). Drives the SPI slave block's CLK/SC0/MOSI and captures MISO.
//  Sits between the heater controller (issues START + DATA_TX) and the off-chip/slave side (ADC or peer).
//  One WIDTH-bit word per transaction; SC0 framed per word; START/BUSY/DONE handshake to the controller.
// PARAMETERS
//  WIDTH   12  bits per transaction (matches the slave's WIDTH)
//  CLKDIV  4   system clocks per SCLK half-period; legal range >= 1
// PORTS
//  CLK      in   1      system clock, all logic on rising edge
//  nRST     in   1      synchronous reset, active-low
//  START    in   1      request transfer; sampled only in IDLE
//  DATA_TX  in   WIDTH  word to send on MOSI; latched when START is accepted
//  BUSY     out  1      high from the cycle after START is accepted through the DONE cycle
//  DONE     out  1      one-cycle pulse: DATA_RX valid, SC0 released
//  DATA_RX  out  WIDTH  last word received on MISO; held until the next DONE
//  SCLK     out  1      SPI clock to the slave's CLK; idles low
//  MOSI     out  1      serial data out, MSB first
//  MISO     in   1      serial data in from slave
//  SC0      out  1      chip select, active-low; idles high
// BEHAVIOUR
//  Reset (nRST=0 at a CLK edge): state=IDLE, SC0=1, SCLK=0, MOSI=0, BUSY=0, DONE=0, DATA_RX=0, counters=0.
//  FSM: IDLE -> SETUP -> XFER -> HOLD -> FIN -> IDLE.
//   IDLE : START=1 -> latch DATA_TX into tx_sr, bit_cnt=0, go SETUP.
//   SETUP: SC0=0, SCLK=0, MOSI=tx_sr[WIDTH-1]; lasts CLKDIV cycles.
//   XFER : div counter 0..CLKDIV-1; on terminal count SCLK toggles.
//          SCLK 0->1: rx_sr <= {rx_sr[WIDTH-2:0], MISO}.
//          SCLK 1->0: tx_sr shifts left, MOSI <= next bit, bit_cnt++; after the WIDTH-th falling edge -> HOLD.
//          Duration exactly 2*WIDTH*CLKDIV cycles.
//   HOLD : SCLK=0, SC0=0, MOSI=0; CLKDIV cycles (slave hold time).
//   FIN  : SC0=1, DATA_RX <= rx_sr, DONE=1 for exactly this cycle; -> IDLE.
//  Latency: START sampled at edge 0 -> DONE high after edge (2*WIDTH+2)*CLKDIV+1 (105 for defaults).
//  MOSI changes only while SCLK is low; MISO is sampled on the system edge that sets SCLK high.
//  START while BUSY (SETUP/XFER/HOLD/FIN): ignored, not queued. START must be re-asserted in IDLE.
//  DATA_TX changes after acceptance: no effect on the current word.
//  Min SC0 high between words: 2 cycles (FIN + IDLE); START held high gives back-to-back words.
//  Reset mid-transfer: abort at once, SC0=1, SCLK=0, no DONE pulse, DATA_RX=0.
//  Widths: bit_cnt $clog2(WIDTH+1) bits; div counter $clog2(CLKDIV)+1 bits; no wrap inside one transfer.
// STRUCTURE
//  spi_defs.vh (shared with the SPI slave): FSM state localparams, default WIDTH, SPI mode constants.
//  One sub-module: spi_clk_gen (CLKDIV divider, outputs rise_tick/fall_tick, cleared while not XFER).
//  Shift registers, bit counter and FSM stay in spi_master.
// TESTING
//  Loopback MISO=MOSI, DATA_TX=12'hA5C, START 1 cycle -> DONE once, DATA_RX=12'hA5C, BUSY fell with DONE.
//  Master -> SPI slave (WIDTH=12), DATA_TX=12'b110101_101011, slave DATA_MISO=12'b010011_001100
//   -> slave DATA_MOSI=12'b110101_101011 with dflag; master DATA_RX=12'b010011_001100.
//  Timing, CLKDIV=4: SC0 low for exactly 104 cycles, 12 SCLK rising edges, SCLK period 8 cycles,
//   DONE exactly 105 cycles after START; CLKDIV=1 repeats with period 2 and DONE at 27.
//  START pulsed at cycle 30 of a transfer -> ignored, one DONE only, DATA_TX change mid-word has no effect.
//  nRST low at cycle 50 of a transfer -> next edge SC0=1, SCLK=0, BUSY=0, DATA_RX=0, no DONE; fresh START works.
//  START held high across 3 words (12'h001, 12'h800, 12'hFFF looped) -> 3 DONEs, SC0 high 2 cycles between.

Source files
------------

// File: rtl/spi_master_pkg.sv
// rtl/spi_master_pkg.sv - shared SPI definitions: FSM states, default geometry, mode constants
package spi_master_pkg;

  // Default word width, shared with the SPI slave
  localparam int SPI_WIDTH_DEF  = 12;
  // Default system clocks per SCLK half-period
  localparam int SPI_CLKDIV_DEF = 4;

  // Mode 0: SCLK idles low, data sampled on the rising edge
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_XFER,
    ST_HOLD,
    ST_FIN
  } spi_state_e;

endpackage

// File: rtl/spi_clk_gen.sv
// rtl/spi_clk_gen.sv - SCLK half-period divider producing alternating rise/fall ticks
module spi_clk_gen #(
  parameter int CLKDIV = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic rise_tick_o,
  output logic fall_tick_o
);

  localparam int CW = $clog2(CLKDIV) + 1;

  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic          phase_q, phase_d;
  logic          tc;

  // Terminal count of one half-period; only meaningful while enabled
  assign tc          = en_i && (div_cnt_q == CW'(CLKDIV - 1));
  // First tick of a transfer is a rising edge, then they alternate
  assign rise_tick_o = tc & ~phase_q;
  assign fall_tick_o = tc &  phase_q;

  // Divider counts while enabled and is held cleared otherwise
  always_comb begin
    div_cnt_d = div_cnt_q;
    phase_d   = phase_q;
    if (!en_i) begin
      div_cnt_d = '0;
      phase_d   = 1'b0;
    end else if (tc) begin
      div_cnt_d = '0;
      phase_d   = ~phase_q;
    end else begin
      div_cnt_d = div_cnt_q + 1'b1;
    end
  end

  // Divider state register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      div_cnt_q <= '0;
      phase_q   <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      phase_q   <= phase_d;
    end
  end

endmodule

// File: rtl/spi_master.sv
// rtl/spi_master.sv - full-duplex mode-0 SPI master, one WIDTH-bit word per chip-select frame
module spi_master
  import spi_master_pkg::*;
#(
  parameter int WIDTH  = SPI_WIDTH_DEF,
  parameter int CLKDIV = SPI_CLKDIV_DEF
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             START,
  input  logic [WIDTH-1:0] DATA_TX,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] DATA_RX,
  output logic             SCLK,
  output logic             MOSI,
  input  logic             MISO,
  output logic             SC0
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam int CW = $clog2(CLKDIV) + 1;

  spi_state_e       state_q, state_d;
  logic [WIDTH-1:0] tx_sr_q, tx_sr_d;
  logic [WIDTH-1:0] rx_sr_q, rx_sr_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]    wait_cnt_q, wait_cnt_d;

  // All pins are registered so the slave sees glitch-free SCLK/SC0/MOSI;
  // they reflect the state held during the preceding cycle.
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] data_rx_q, data_rx_d;
  logic             sclk_q, sclk_d;
  logic             mosi_q, mosi_d;
  logic             sc0_q, sc0_d;

  logic rise_tick, fall_tick;

  spi_clk_gen #(.CLKDIV(CLKDIV)) u_clk_gen (
    .clk_i       (CLK),
    .rst_ni      (nRST),
    .en_i        (state_q == ST_XFER),
    .rise_tick_o (rise_tick),
    .fall_tick_o (fall_tick)
  );

  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign DATA_RX = data_rx_q;
  assign SCLK    = sclk_q;
  assign MOSI    = mosi_q;
  assign SC0     = sc0_q;

  // Next-state, shift-register and pin logic for the framing FSM
  always_comb begin
    state_d    = state_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    bit_cnt_d  = bit_cnt_q;
    wait_cnt_d = '0;
    busy_d     = (state_q != ST_IDLE);
    done_d     = 1'b0;
    data_rx_d  = data_rx_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    sc0_d      = !(state_q inside {ST_SETUP, ST_XFER, ST_HOLD});

    unique case (state_q)
      ST_IDLE: begin
        sclk_d = SPI_CPOL;
        mosi_d = 1'b0;
        if (START) begin
          tx_sr_d   = DATA_TX;
          bit_cnt_d = '0;
          state_d   = ST_SETUP;
        end
      end
      ST_SETUP: begin
        // Present the MSB a full half-period before the first rising edge
        sclk_d = SPI_CPOL;
        mosi_d = tx_sr_q[WIDTH-1];
        if (wait_cnt_q == CW'(CLKDIV - 1)) begin
          state_d = ST_XFER;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      ST_XFER: begin
        if (rise_tick) begin
          sclk_d  = 1'b1;
          rx_sr_d = {rx_sr_q[WIDTH-2:0], MISO};
        end
        if (fall_tick) begin
          sclk_d    = 1'b0;
          tx_sr_d   = tx_sr_q << 1;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BW'(WIDTH - 1)) begin
            mosi_d  = 1'b0;
            state_d = ST_HOLD;
          end else begin
            mosi_d = tx_sr_q[WIDTH-2];
          end
        end
      end
      ST_HOLD: begin
        // Keep chip select low for the slave's hold time
        sclk_d = SPI_CPOL;
        mosi_d = 1'b0;
        if (wait_cnt_q == CW'(CLKDIV - 1)) begin
          state_d = ST_FIN;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      ST_FIN: begin
        done_d    = 1'b1;
        data_rx_d = rx_sr_q;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, datapath and pin registers; reset aborts any transfer immediately
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q    <= ST_IDLE;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      bit_cnt_q  <= '0;
      wait_cnt_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      data_rx_q  <= '0;
      sclk_q     <= SPI_CPOL;
      mosi_q     <= 1'b0;
      sc0_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      bit_cnt_q  <= bit_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      data_rx_q  <= data_rx_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      sc0_q      <= sc0_d;
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - randomized bench for spi_master against a behavioural SPI slave model
module tb_spi_master;

  localparam int W = 12;
  localparam int C = 4;
  localparam int LAT   = (2 * W + 2) * C + 1;
  localparam int LOW   = (2 * W + 2) * C;
  localparam int LAT_F = (2 * W + 2) * 1 + 1;
  localparam int LOW_F = (2 * W + 2) * 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         nrst, start, miso;
  logic [W-1:0] data_tx;
  logic         busy, done, sclk, mosi, sc0;
  logic [W-1:0] data_rx;

  logic         start_f;
  logic [W-1:0] data_tx_f;
  logic         busy_f, done_f, sclk_f, mosi_f, sc0_f, miso_f;
  logic [W-1:0] data_rx_f;

  assign miso_f = mosi_f;

  spi_master #(.WIDTH(W), .CLKDIV(C)) u_dut (
    .CLK(clk), .nRST(nrst), .START(start), .DATA_TX(data_tx), .BUSY(busy), .DONE(done),
    .DATA_RX(data_rx), .SCLK(sclk), .MOSI(mosi), .MISO(miso), .SC0(sc0)
  );

  spi_master #(.WIDTH(W), .CLKDIV(1)) u_dut_fast (
    .CLK(clk), .nRST(nrst), .START(start_f), .DATA_TX(data_tx_f), .BUSY(busy_f), .DONE(done_f),
    .DATA_RX(data_rx_f), .SCLK(sclk_f), .MOSI(mosi_f), .MISO(miso_f), .SC0(sc0_f)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave model and pin observer for the CLKDIV=C instance
  logic [W-1:0] slave_word = '0;
  bit           loop_m     = 1'b0;
  logic [W-1:0] cap = '0;
  logic sclk_p = 1'b0, sc0_p = 1'b1, mosi_p = 1'b0;
  int sidx = W - 1;
  int rises = 0, sc0_low = 0, dones = 0, bad_per = 0, bad_mosi = 0;
  int frame_rises = 0, last_rise = 0, last_per = 0, high_run = 0, last_gap = 0;

  always @(negedge clk) begin
    if (!sc0) begin
      sc0_low++;
      if (sc0_p) last_gap = high_run;
    end else begin
      high_run = sc0_p ? high_run + 1 : 1;
    end
    if (done) dones++;
    if (mosi !== mosi_p && sclk && sclk_p) bad_mosi++;
    if (sc0) begin
      sidx = W - 1;
      frame_rises = 0;
    end else begin
      if (sclk && !sclk_p) begin
        rises++;
        cap = {cap[W-2:0], mosi};
        if (frame_rises > 0) begin
          last_per = cyc - last_rise;
          if (last_per != 2 * C) bad_per++;
        end
        last_rise = cyc;
        frame_rises++;
      end
      if (!sclk && sclk_p) sidx--;
    end
    miso = loop_m ? mosi : ((sidx >= 0) ? slave_word[sidx] : 1'b0);
    sclk_p = sclk;
    sc0_p  = sc0;
    mosi_p = mosi;
  end

  // Pin observer for the CLKDIV=1 loopback instance
  logic sclk_pf = 1'b0;
  int rises_f = 0, sc0_low_f = 0, last_rise_f = 0, last_per_f = 0;

  always @(negedge clk) begin
    if (!sc0_f) sc0_low_f++;
    if (!sc0_f && sclk_f && !sclk_pf) begin
      if (rises_f > 0) last_per_f = cyc - last_rise_f;
      last_rise_f = cyc;
      rises_f++;
    end
    sclk_pf = sclk_f;
  end

  task automatic run_word(input logic [W-1:0] tx, input logic [W-1:0] sw, input bit lp,
                          input bit glitch, input string tag);
    int r0, l0, d0, b0, t0;
    bit seen;
    logic [W-1:0] exp_rx;
    data_tx = tx;
    slave_word = sw;
    loop_m = lp;
    exp_rx = lp ? tx : sw;
    @(posedge clk); #1;
    start = 1'b1;
    r0 = rises; l0 = sc0_low; d0 = dones; b0 = bad_per;
    @(posedge clk); #1;
    t0 = cyc;
    start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge clk);
      if (glitch && cyc - t0 == 30) begin
        start = 1'b1;
        data_tx = ~tx;
      end else if (glitch && cyc - t0 == 31) begin
        start = 1'b0;
      end
      if (done) seen = 1'b1;
    end
    check({tag, " done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({tag, " latency"}, cyc - t0, LAT);
      check({tag, " busy_at_done"}, 32'(busy), 32'd1);
      check({tag, " data_rx"}, 32'(data_rx), 32'(exp_rx));
      check({tag, " mosi_word"}, 32'(cap), 32'(tx));
      @(negedge clk);
      check({tag, " busy_after"}, 32'(busy), 32'd0);
      check({tag, " done_after"}, 32'(done), 32'd0);
    end
    repeat (3) @(negedge clk);
    check({tag, " sclk_rises"}, rises - r0, W);
    check({tag, " sc0_low"}, sc0_low - l0, LOW);
    check({tag, " done_pulses"}, dones - d0, 1);
    check({tag, " bad_periods"}, bad_per - b0, 0);
    check({tag, " sclk_period"}, last_per, 2 * C);
  endtask

  task automatic run_reset_abort();
    int t0, d0;
    data_tx = 12'h3C6;
    loop_m = 1'b1;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    t0 = cyc;
    start = 1'b0;
    while (cyc - t0 < 50) @(posedge clk);
    #1;
    nrst = 1'b0;
    @(posedge clk); #1;
    check("rst sc0", 32'(sc0), 32'd1);
    check("rst sclk", 32'(sclk), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst data_rx", 32'(data_rx), 32'd0);
    check("rst done", 32'(done), 32'd0);
    nrst = 1'b1;
    d0 = dones;
    repeat (150) @(negedge clk);
    check("rst no_done", dones - d0, 0);
    check("rst sc0_idle", 32'(sc0), 32'd1);
  endtask

  task automatic run_back_to_back();
    logic [W-1:0] words [3];
    int d0;
    bit ok;
    words[0] = 12'h001; words[1] = 12'h800; words[2] = 12'hFFF;
    loop_m = 1'b1;
    data_tx = words[0];
    d0 = dones;
    @(posedge clk); #1;
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ok = 1'b0;
      for (int k = 0; k < 10 && !ok; k++) begin
        @(negedge clk);
        if (!busy) ok = 1'b1;
      end
      ok = 1'b0;
      for (int k = 0; k < 10 && !ok; k++) begin
        @(negedge clk);
        if (busy) ok = 1'b1;
      end
      check("b2b busy_rise", 32'(ok), 32'd1);
      if (i < 2) data_tx = words[i+1];
      ok = 1'b0;
      for (int k = 0; k < 200 && !ok; k++) begin
        @(negedge clk);
        if (done) ok = 1'b1;
      end
      check("b2b done_seen", 32'(ok), 32'd1);
      check("b2b data_rx", 32'(data_rx), 32'(words[i]));
      if (i == 2) start = 1'b0;
    end
    repeat (4) @(negedge clk);
    check("b2b done_pulses", dones - d0, 3);
    check("b2b sc0_gap", last_gap, 2);
  endtask

  task automatic run_fast(input logic [W-1:0] tx);
    int r0, l0, t0;
    bit seen;
    data_tx_f = tx;
    @(posedge clk); #1;
    start_f = 1'b1;
    r0 = rises_f; l0 = sc0_low_f;
    @(posedge clk); #1;
    t0 = cyc;
    start_f = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (done_f) seen = 1'b1;
    end
    check("fast done_seen", 32'(seen), 32'd1);
    if (seen) begin
      check("fast latency", cyc - t0, LAT_F);
      check("fast data_rx", 32'(data_rx_f), 32'(tx));
    end
    repeat (3) @(negedge clk);
    check("fast sclk_rises", rises_f - r0, W);
    check("fast sc0_low", sc0_low_f - l0, LOW_F);
    check("fast sclk_period", last_per_f, 2);
  endtask

  initial begin
    nrst = 1'b0;
    start = 1'b0;
    data_tx = '0;
    start_f = 1'b0;
    data_tx_f = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset sc0", 32'(sc0), 32'd1);
    check("reset sclk", 32'(sclk), 32'd0);
    check("reset mosi", 32'(mosi), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset data_rx", 32'(data_rx), 32'd0);
    nrst = 1'b1;
    repeat (2) @(posedge clk);

    run_word(12'hA5C, 12'h000, 1'b1, 1'b0, "loopback");
    run_word(12'b110101_101011, 12'b010011_001100, 1'b0, 1'b0, "slave");
    run_word(12'h6E1, 12'h93B, 1'b0, 1'b1, "glitch");
    for (int n = 0; n < 6; n++) begin
      run_word(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b0, "random");
    end
    run_reset_abort();
    run_word(12'h5A3, 12'hC3E, 1'b0, 1'b0, "after_reset");
    run_back_to_back();
    run_fast(12'hA5C);
    run_fast(W'($urandom));
    check("mosi_stable_while_sclk_high", bad_mosi, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
